// File: rtl/addpath_ctrl.sv
// Add-datapath sequencer: fetches instructions from the shared RAM, reads two operands, and writes back their sum.
// Optional carry-out tracking into ovf is enabled by defining ADDPATH_OVF_EN.
module addpath_ctrl #(
  parameter logic [15:0] START_PC  = 16'h0000,
  parameter logic [15:0] DATA_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] adr,
  output logic [63:0] writeData,
  output logic        readEn,
  output logic        writeEn,
  input  logic [63:0] readData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pc,
  output logic        ovf
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | read instruction at pc and decode its opcode
  // RDA   | read operand A
  // RDB   | read operand B
  // WB    | write A+B to dst, advance pc
  // HALT  | stopped; done high until the next start
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RDA, S_RDB, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_HALT = 7'd0;
  localparam logic [6:0] OP_NOP  = 7'd1;
  localparam logic [6:0] OP_ADD  = 7'd2;

  state_t      state, state_nx;
  logic [17:0] ir;
  logic [63:0] a, b;
  logic [63:0] sum;
  logic [6:0]  fetch_op;
  logic [15:0] adr_a, adr_b, adr_d;
  logic        start_ok;
  logic        unused_rd;

  assign fetch_op  = readData[24:18];
  assign unused_rd = ^readData[63:25];
  assign adr_a     = DATA_BASE + {10'b0, ir[5:0]};
  assign adr_b     = DATA_BASE + {10'b0, ir[11:6]};
  assign adr_d     = DATA_BASE + {10'b0, ir[17:12]};
  assign start_ok  = start && (state == S_IDLE || state == S_HALT);

`ifdef ADDPATH_OVF_EN
  logic [64:0] sum_ext;
  logic        ovf_q;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign sum     = sum_ext[63:0];
  assign ovf     = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (start_ok)
      ovf_q <= 1'b0;
    else if (state == S_WB)
      ovf_q <= ovf_q | sum_ext[64];
  end
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= START_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc  <= START_PC;
            err <= 1'b0;
          end
        end
        S_FETCH: begin
          ir <= readData[17:0];
          if (fetch_op == OP_NOP)
            pc <= pc + 16'd1;
          else if (fetch_op != OP_HALT && fetch_op != OP_ADD)
            err <= 1'b1;
        end
        S_RDA: a <= readData;
        S_RDB: b <= readData;
        S_WB:  pc <= pc + 16'd1;
        default: ;
      endcase
    end
  end

  // RAM-side outputs depend on registered state only; start and readData steer state_nx alone.
  always_comb begin
    state_nx  = state;
    adr       = 16'h0000;
    readEn    = 1'b0;
    writeEn   = 1'b0;
    writeData = 64'h0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        adr    = pc;
        readEn = 1'b1;
        case (fetch_op)
          OP_HALT: state_nx = S_HALT;
          OP_NOP:  state_nx = S_FETCH;
          OP_ADD:  state_nx = S_RDA;
          default: state_nx = S_HALT;
        endcase
      end
      S_RDA: begin
        busy     = 1'b1;
        adr      = adr_a;
        readEn   = 1'b1;
        state_nx = S_RDB;
      end
      S_RDB: begin
        busy     = 1'b1;
        adr      = adr_b;
        readEn   = 1'b1;
        state_nx = S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        adr       = adr_d;
        writeEn   = 1'b1;
        writeData = sum;
        state_nx  = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
